// File: rtl/rv32_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32_ctrl_pkg
// Shared RV32 decode definitions: base opcodes, immediate-select and
// writeback-select encodings, ALU / M-extension operation codes and the
// control bundle passed from the combinational decoder to the decode stage.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32_ctrl_pkg;

    // Base-ISA major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // fun7 value that turns an OP instruction into an RV32M operation
    localparam logic [6:0] FUN7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        MTR_ALU = 2'd0,
        MTR_MEM = 2'd1,
        MTR_PC4 = 2'd2
    } mem_to_reg_e;

    localparam int unsigned ALU_CODE_W = 5;

    // Base ALU codes; M-extension codes occupy 16..23 (16 + fun3)
    localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 5'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 5'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL   = 5'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT   = 5'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU  = 5'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR   = 5'd5;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL   = 5'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA   = 5'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_OR    = 5'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_AND   = 5'd9;
    localparam logic [ALU_CODE_W-1:0] ALU_PASSB = 5'd10;
    localparam logic [ALU_CODE_W-1:0] ALU_MUL   = 5'd16;

    typedef struct packed {
        logic                  reg_write;
        logic                  operand_a;
        logic                  operand_b;
        logic                  load;
        logic                  store;
        logic                  branch;
        logic                  jal;
        logic                  jalr;
        logic                  muldiv;
        logic                  illegal;
        imm_sel_e              imm_sel;
        mem_to_reg_e           mem_to_reg;
        logic [ALU_CODE_W-1:0] alu_ctrl;
    } ctrl_bundle_t;

    // ALU op for OP / OP-IMM by fun3. The alternate bit (fun7[5]) picks SUB
    // only for register-register adds, so ADDI never becomes a subtract,
    // while it picks SRA for both shift forms.
    function automatic logic [ALU_CODE_W-1:0] aluFromFun3(
        input logic [2:0] fun3,
        input logic       alt,
        input logic       isRegReg
    );
        logic [ALU_CODE_W-1:0] code;
        case (fun3)
            3'b000:  code = (isRegReg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // M-extension code: MUL base plus fun3 (MUL..REMU)
    function automatic logic [ALU_CODE_W-1:0] mulDivCode(input logic [2:0] fun3);
        return ALU_MUL | {2'b00, fun3};
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// ---------------------------------------------------------------------------
// ctrl_decode_comb
// Purely combinational RV32I(+M) control decoder.
// Parameters:
//   ENABLE_M   1 = decode RV32M ops, 0 = report them as illegal
// Ports:
//   i_opcode   instr[6:0]
//   i_fun3     instr[14:12]
//   i_fun7     instr[31:25]
//   o_bundle   decoded control bundle (all zero except illegal for bad ops)
// ---------------------------------------------------------------------------
module ctrl_decode_comb
    import rv32_ctrl_pkg::*;
#(
    parameter int ENABLE_M = 0
) (
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_fun3,
    input  logic [6:0]   i_fun7,
    output ctrl_bundle_t o_bundle
);

    // Every field starts at zero so unused selects stay quiet and an illegal
    // instruction carries nothing but the illegal flag.
    always_comb begin
        o_bundle = '0;
        case (i_opcode)
            OPC_OP: begin
                if (i_fun7 == FUN7_MULDIV) begin
                    if (ENABLE_M != 0) begin
                        o_bundle.reg_write = 1'b1;
                        o_bundle.muldiv    = 1'b1;
                        o_bundle.alu_ctrl  = mulDivCode(i_fun3);
                    end else begin
                        o_bundle.illegal   = 1'b1;
                    end
                end else begin
                    o_bundle.reg_write = 1'b1;
                    o_bundle.alu_ctrl  = aluFromFun3(i_fun3, i_fun7[5], 1'b1);
                end
            end
            OPC_OP_IMM: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.operand_b = 1'b1;
                o_bundle.imm_sel   = IMM_I;
                o_bundle.alu_ctrl  = aluFromFun3(i_fun3, i_fun7[5], 1'b0);
            end
            OPC_LOAD: begin
                o_bundle.reg_write  = 1'b1;
                o_bundle.operand_b  = 1'b1;
                o_bundle.load       = 1'b1;
                o_bundle.imm_sel    = IMM_I;
                o_bundle.mem_to_reg = MTR_MEM;
                o_bundle.alu_ctrl   = ALU_ADD;
            end
            OPC_STORE: begin
                o_bundle.operand_b = 1'b1;
                o_bundle.store     = 1'b1;
                o_bundle.imm_sel   = IMM_S;
                o_bundle.alu_ctrl  = ALU_ADD;
            end
            OPC_BRANCH: begin
                // Both operands are registers; the ALU compares by subtracting
                o_bundle.branch   = 1'b1;
                o_bundle.imm_sel  = IMM_B;
                o_bundle.alu_ctrl = ALU_SUB;
            end
            OPC_JAL: begin
                o_bundle.reg_write  = 1'b1;
                o_bundle.operand_a  = 1'b1;
                o_bundle.jal        = 1'b1;
                o_bundle.imm_sel    = IMM_J;
                o_bundle.mem_to_reg = MTR_PC4;
                o_bundle.alu_ctrl   = ALU_ADD;
            end
            OPC_JALR: begin
                o_bundle.reg_write  = 1'b1;
                o_bundle.operand_b  = 1'b1;
                o_bundle.jalr       = 1'b1;
                o_bundle.imm_sel    = IMM_I;
                o_bundle.mem_to_reg = MTR_PC4;
                o_bundle.alu_ctrl   = ALU_ADD;
            end
            OPC_LUI: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.operand_b = 1'b1;
                o_bundle.imm_sel   = IMM_U;
                o_bundle.alu_ctrl  = ALU_PASSB;
            end
            OPC_AUIPC: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.operand_a = 1'b1;
                o_bundle.operand_b = 1'b1;
                o_bundle.imm_sel   = IMM_U;
                o_bundle.alu_ctrl  = ALU_ADD;
            end
            default: begin
                o_bundle.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// ---------------------------------------------------------------------------
// decode_ctrl_stage
// Decode-stage control register: wraps ctrl_decode_comb with the valid/ready
// handshake, stall hold, flush kill and the multiply/divide issue blocker.
// Parameters:
//   ENABLE_M        1 = accept RV32M ops, 0 = flag them illegal
//   MULDIV_LATENCY  issue-blocking cycles per accepted M op (1..15)
//   ALU_CTRL_W      alu_control width (>= 5)
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid        instruction present in decode
//   in_ready        stage accepts an instruction this cycle
//   opcode/fun3/fun7  instruction fields
//   stall           EX cannot accept, hold the registered bundle
//   flush           kill the registered bundle (branch redirect)
//   out_valid       registered bundle valid for EX
//   reg_write..illegal, imm_sel, mem_to_reg, alu_control  registered controls
//   md_busy         M op in flight, issue blocked
// ---------------------------------------------------------------------------
module decode_ctrl_stage
    import rv32_ctrl_pkg::*;
#(
    parameter int          ENABLE_M       = 0,
    parameter int unsigned MULDIV_LATENCY = 4,
    parameter int unsigned ALU_CTRL_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            fun3,
    input  logic [6:0]            fun7,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    output logic                  reg_write,
    output logic                  operand_a,
    output logic                  operand_b,
    output logic                  load,
    output logic                  store,
    output logic                  branch,
    output logic                  jal,
    output logic                  jalr,
    output logic                  muldiv,
    output logic                  illegal,
    output logic [2:0]            imm_sel,
    output logic [1:0]            mem_to_reg,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  md_busy
);

    localparam logic [3:0] MD_LOAD = 4'(MULDIV_LATENCY - 1);

    ctrl_bundle_t w_decoded;
    logic         w_transfer;

    ctrl_bundle_t r_bundle;
    logic         r_outValid;
    logic [3:0]   r_mdCount;

    ctrl_decode_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .i_opcode (opcode),
        .i_fun3   (fun3),
        .i_fun7   (fun7),
        .o_bundle (w_decoded)
    );

    // Reset is folded into ready so nothing is accepted in a reset cycle.
    assign md_busy    = (r_mdCount != 4'd0);
    assign in_ready   = !rst && !stall && !md_busy && !flush;
    assign w_transfer = in_valid && in_ready;

    // Bundle register: reset/flush kill, stall holds, otherwise either the
    // newly decoded instruction or a bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_outValid <= 1'b0;
            r_bundle   <= '0;
        end else if (stall) begin
            r_outValid <= r_outValid;
            r_bundle   <= r_bundle;
        end else if (w_transfer) begin
            r_outValid <= 1'b1;
            r_bundle   <= w_decoded;
        end else begin
            r_outValid <= 1'b0;
            r_bundle   <= '0;
        end
    end

    // Multiply/divide blocker. Loading LATENCY-1 gives LATENCY-1 busy cycles
    // after the issue cycle, so a latency of 1 never raises md_busy. It keeps
    // counting through stalls since the M unit itself is not stalled.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_mdCount <= 4'd0;
        end else if (w_transfer && w_decoded.muldiv) begin
            r_mdCount <= MD_LOAD;
        end else if (r_mdCount != 4'd0) begin
            r_mdCount <= r_mdCount - 4'd1;
        end
    end

    assign out_valid   = r_outValid;
    assign reg_write   = r_bundle.reg_write;
    assign operand_a   = r_bundle.operand_a;
    assign operand_b   = r_bundle.operand_b;
    assign load        = r_bundle.load;
    assign store       = r_bundle.store;
    assign branch      = r_bundle.branch;
    assign jal         = r_bundle.jal;
    assign jalr        = r_bundle.jalr;
    assign muldiv      = r_bundle.muldiv;
    assign illegal     = r_bundle.illegal;
    assign imm_sel     = r_bundle.imm_sel;
    assign mem_to_reg  = r_bundle.mem_to_reg;
    assign alu_control = ALU_CTRL_W'(r_bundle.alu_ctrl);

endmodule

// File: doc/decode_ctrl_stage.md
DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 Parameter ENABLE_M, default 0, meaning: 1 accepts RV32M ops (opcode 0110011, fun7 0000001); 0 flags them illegal.
REQ-002 Parameter MULDIV_LATENCY, default 4, meaning: issue-blocking cycles per accepted M op, range 1..15.
REQ-003 Parameter ALU_CTRL_W, default 5, meaning: alu_control width, minimum 5.
REQ-004 One clock, clk; reset rst, synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  decode-stage instruction present.
REQ-008 in_ready  out  1  stage accepts instruction this cycle.
REQ-009 opcode  in  7  instr[6:0].
REQ-010 fun3  in  3  instr[14:12].
REQ-011 fun7  in  7  instr[31:25].
REQ-012 stall  in  1  EX stage cannot accept; hold outputs.
REQ-013 flush  in  1  kill registered bundle (branch redirect).
REQ-014 out_valid  out  1  registered bundle valid for EX.
REQ-015 reg_write, operand_a, operand_b, load, store, branch, jal, jalr, muldiv, illegal  out  1 each  registered control bits.
REQ-016 imm_sel  out  3  I=0, S=1, B=2, U=3, J=4.
REQ-017 mem_to_reg  out  2  0 ALU, 1 memory, 2 PC+4.
REQ-018 alu_control  out  ALU_CTRL_W  ALU op code from shared package.
REQ-019 md_busy  out  1  M op in flight; issue blocked.

Function
REQ-020 in_ready SHALL equal !stall && !md_busy && !flush, combinationally.
REQ-021 Transfer SHALL occur when in_valid && in_ready; bundle SHALL appear on outputs one cycle later with out_valid=1.
REQ-022 No transfer and no stall: next cycle out_valid=0 and every control output 0 (bubble).
REQ-023 stall=1 and no flush: all outputs SHALL hold their values.
REQ-024 flush SHALL take priority over stall and transfer: next cycle out_valid=0, all control outputs 0, md counter cleared.
REQ-025 Decode: R 0110011, I 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
REQ-026 operand_b=1 (immediate) for I, load, store, jalr, lui, auipc; operand_a=1 (PC) for auipc, jal; lui uses ALU pass-B.
REQ-027 fun7[5] selects SUB/SRA for R-type, and SRA for I-type fun3=101 only; ADDI SHALL ignore fun7.
REQ-028 reg_write=1 for R, I, load, jal, jalr, lui, auipc, M; mem_to_reg=2 for jal/jalr, 1 for load, else 0.
REQ-029 Illegal opcode, or M op with ENABLE_M=0: out_valid=1, illegal=1, reg_write/store/load/branch/jal/jalr=0.
REQ-030 Accepted M op: muldiv=1, alu_control = M code for fun3; 4-bit counter loads MULDIV_LATENCY-1.
REQ-031 md_busy SHALL be (counter!=0); counter decrements by 1 each cycle independent of stall, saturating at 0.
REQ-032 MULDIV_LATENCY=1: md_busy SHALL never assert.

Reset
REQ-033 rst=1 SHALL clear out_valid, all control outputs and md counter to 0 next edge, overriding flush, stall and transfer, including mid-M-op.
REQ-034 During and in the cycle of reset, in_ready SHALL be 0.

Structure
REQ-035 Opcode constants, imm_sel encodings, mem_to_reg encodings and ALU/M alu_control codes SHALL live in shared package rv32_ctrl_pkg.
REQ-036 Combinational decode SHALL be one sub-module, ctrl_decode_comb; this block adds registers, handshake and md counter.

Verification
REQ-037 rst then add x1,x2,x3 (0110011/000/0000000), stall=0 -> next cycle out_valid=1, reg_write=1, operand_b=0, alu_control=ADD.
REQ-038 sw accepted then stall=1 three cycles -> store=1, imm_sel=1 held for all three; in_ready=0 throughout.
REQ-039 ENABLE_M=1, MULDIV_LATENCY=4, mul accepted -> md_busy=1 for 3 cycles, in_ready=0, muldiv=1; ENABLE_M=0 same op -> illegal=1, reg_write=0.
REQ-040 flush and stall together with jal pending -> next cycle out_valid=0, jal=0.
REQ-041 opcode 1111111 -> illegal=1, out_valid=1; srai fun7=0100000 -> SRA; addi fun7=0100000 -> ADD.
REQ-042 rst asserted two cycles into M op -> md_busy=0 and out_valid=0 next cycle.
